native_mem_responder: RTL
=========================

Name: native_mem_responder

Overview:
- Responder (memory-side) end of the picorv32 native memory interface (mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb -> mem_ready/mem_rdata).
- Synthesizable memory model for core testbenches and formal harnesses:
  - word-addressed RAM with byte-lane writes;
  - programmable base latency plus bounded externally-driven stalls;
  - sticky flags for initiator protocol violations and out-of-range accesses.

Parameters:
MEM_WORDS, 256, number of 32-bit words; power of two, >= 4
ADDR_BASE, 32'h0000_0000, byte address of word 0; MEM_WORDS*4-aligned
WAIT_CYCLES, 1, fixed wait states before ready; 0..15
MAX_STALL, 4, max consecutive stall cycles honoured per request; 0..15

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mem_valid  input  1  request valid from initiator
mem_instr  input  1  request is instruction fetch
mem_addr  input  32  byte address
mem_wdata  input  32  write data
mem_wstrb  input  4  byte write enables; 0 = read
mem_ready  output  1  response strobe, exactly one cycle per request
mem_rdata  output  32  read data, valid while mem_ready=1
stall  input  1  extra wait-state request (free input in formal benches)
protocol_error  output  1  sticky: initiator violated handshake rules
range_error  output  1  sticky: misaligned or out-of-window access
busy  output  1  request captured, response not yet given

Behaviour:
- Reset (sync, active-high):
  - state IDLE; mem_ready=0, mem_rdata=0, busy=0;
  - protocol_error=0, range_error=0; counters cleared.
  - RAM contents are not cleared.
  - Reset asserted mid-request abandons the request: no ready, no write.
- All outputs are registered.
- IDLE:
  - If mem_valid=1 and mem_ready=0: capture addr/wdata/wstrb/instr; load wait counter with WAIT_CYCLES; stall counter=0; go WAIT; busy=1.
- WAIT, each cycle:
  - stall=1 and stall counter < MAX_STALL: increment stall counter; wait counter frozen.
  - Otherwise: if wait counter = 0, go RESP; else decrement.
- RESP:
  - mem_ready=1 for exactly one cycle; state returns to IDLE; busy=0.
  - Read (wstrb=0): mem_rdata = RAM[index].
  - Write: RAM byte lane i updated when wstrb[i]=1; mem_rdata = 0.
- Latency:
  - mem_ready rises WAIT_CYCLES+2 cycles after the capture edge, plus honoured stall cycles.
  - Worst case WAIT_CYCLES+MAX_STALL+2.
- Back-to-back: in the cycle after RESP, mem_valid is still visible while mem_ready drops. IDLE accepts it only when registered mem_ready=0, so a new request is captured no earlier than the second cycle after ready.
- index = (mem_addr - ADDR_BASE) >> 2, modulo 2^32 arithmetic.
- range_error is set at capture when mem_addr[1:0] != 0 or index >= MEM_WORDS. The response is still given: rdata=0, write dropped.
- protocol_error is set in WAIT/RESP when:
  - mem_valid=0, or
  - any of addr/wdata/wstrb/instr differ from the captured values.
- protocol_error is also set at capture when mem_instr=1 and wstrb != 0.
- Response continues regardless of protocol_error.
- Simultaneous error sources in one cycle: each flag is set independently. Flags clear only on reset.

Decomposition:
- Package native_mem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - counter width constant (4 bits);
  - function computing index and range check from addr, base, words.
- Sub-module native_mem_ram:
  - MEM_WORDS x 32 array;
  - one synchronous read port, one byte-masked write port.
- Control FSM, counters and checkers stay in the top module.

Test Plan:
- WAIT_CYCLES=1, no stall: read 0x10 after writing 0xDEADBEEF (wstrb=4'hF) -> ready 3 cycles after capture; rdata=0xDEADBEEF; busy high 3 cycles.
- Byte-lane write wstrb=4'b0010, wdata=0x0000AB00 over 0x11223344 at 0x20 -> subsequent read returns 0x1122AB44.
- stall held high 10 cycles, MAX_STALL=4, WAIT_CYCLES=1 -> ready exactly 7 cycles after capture; no error flags.
- Read addr 0x402 (misaligned) and 0x400 (index 256) -> both respond with rdata=0; range_error=1; RAM unchanged.
- mem_addr changes 0x10->0x14 during WAIT, and a separate request drops mem_valid early -> protocol_error=1 and stays 1; next reset clears it.
- Reset asserted the cycle before RESP of a write to 0x30 -> mem_ready never pulses; word 0x30 keeps its old value; outputs return to 0.

Source files
------------

// File: rtl/native_mem_responder_pkg.sv
// Shared types and helpers for the picorv32 native-memory responder:
// FSM state encoding, counter width and the address-to-word-index check.
package native_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] index;
    logic        bad;
  } idx_chk_t;

  // Word index is taken modulo 2^32 so addresses below the base wrap high and fail the bound.
  function automatic idx_chk_t mem_index_check(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input logic [31:0] words);
    idx_chk_t    r;
    logic [31:0] off;
    off     = addr - base;
    r.index = {2'b00, off[31:2]};
    r.bad   = (addr[1:0] != 2'b00) || (r.index >= words);
    return r;
  endfunction

endpackage

// File: rtl/native_mem_responder_if.sv
// picorv32 native memory bus between an initiator (master) and this responder (slave).
// Handshake: the initiator raises mem_valid and holds valid/instr/addr/wdata/wstrb
// stable until it sees mem_ready=1; mem_ready is a single-cycle strobe per request
// and mem_rdata is meaningful only in that cycle.
interface native_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/native_mem_responder_ram.sv
// Word-organised RAM with one registered read port and one byte-masked write port.
// Contents are deliberately not reset.
module native_mem_ram #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic [AW-1:0] i_addr,
  input  logic          i_rd_en,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [3:0]    i_wstrb,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_q;

  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_rd_en) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/native_mem_responder.sv
// Memory-side responder for the picorv32 native interface: RAM with programmable
// wait states, bounded external stalls and sticky protocol/range error flags.
module native_mem_responder
  import native_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MAX_STALL   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  native_mem_responder_if.slave        mem,
  input  logic                         stall,
  output logic                         protocol_error,
  output logic                         range_error,
  output logic                         busy,
  output state_t                       o_dbg_state
);

  localparam int unsigned      IDX_W       = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] WAIT_C      = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] MAX_STALL_C = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_instr;
  logic [IDX_W-1:0]   r_idx;
  logic               r_range_bad;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic               r_busy;
  logic               r_perr;
  logic               r_rerr;

  logic               w_capture;
  logic               w_stall_inc;
  logic               w_wait_dec;
  logic               w_mismatch;
  logic               w_ram_rd;
  logic               w_ram_we;
  logic [31:0]        w_ram_q;
  idx_chk_t           w_chk;
  logic               w_unused_idx_hi;

  assign w_chk           = mem_index_check(mem.mem_addr, ADDR_BASE, MEM_WORDS);
  assign w_unused_idx_hi = ^w_chk.index[31:IDX_W];

  // Registered mem_ready gates IDLE so the request that was just answered is not re-captured.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_stall_inc  = 1'b0;
    w_wait_dec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem.mem_valid && !r_ready) begin
          w_capture    = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (stall && (r_stall_cnt < MAX_STALL_C)) w_stall_inc = 1'b1;
        else if (r_wait_cnt == '0)                w_state_next = RESP;
        else                                      w_wait_dec = 1'b1;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_mismatch = ((r_state == WAIT) || (r_state == RESP)) &&
                      (!mem.mem_valid || (mem.mem_addr != r_addr) ||
                       (mem.mem_wdata != r_wdata) || (mem.mem_wstrb != r_wstrb) ||
                       (mem.mem_instr != r_instr));

  // RAM is read on entry to RESP so its registered output is ready for the response edge.
  assign w_ram_rd = (r_state == WAIT) && (w_state_next == RESP);
  assign w_ram_we = (r_state == RESP) && !reset && (r_wstrb != 4'b0) && !r_range_bad;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_perr      <= 1'b0;
      r_rerr      <= 1'b0;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (r_state == RESP);
      r_busy  <= (w_state_next != IDLE);
      r_rdata <= ((r_state == RESP) && (r_wstrb == 4'b0) && !r_range_bad) ? w_ram_q : '0;
      if (w_capture) begin
        r_wait_cnt  <= WAIT_C;
        r_stall_cnt <= '0;
        if (w_chk.bad) r_rerr <= 1'b1;
        if (mem.mem_instr && (mem.mem_wstrb != 4'b0)) r_perr <= 1'b1;
      end
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_wait_dec)  r_wait_cnt  <= r_wait_cnt - CNT_ONE;
      if (w_mismatch)  r_perr      <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_addr      <= mem.mem_addr;
      r_wdata     <= mem.mem_wdata;
      r_wstrb     <= mem.mem_wstrb;
      r_instr     <= mem.mem_instr;
      r_idx       <= w_chk.index[IDX_W-1:0];
      r_range_bad <= w_chk.bad;
    end
  end

  native_mem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (IDX_W)
  ) u_ram (
    .clock   (clock),
    .i_addr  (r_idx),
    .i_rd_en (w_ram_rd),
    .o_rdata (w_ram_q),
    .i_we    (w_ram_we),
    .i_wstrb (r_wstrb),
    .i_wdata (r_wdata)
  );

  assign mem.mem_ready   = r_ready;
  assign mem.mem_rdata   = r_rdata;
  assign protocol_error  = r_perr;
  assign range_error     = r_rerr;
  assign busy            = r_busy;
  assign o_dbg_state     = r_state;

endmodule
